// File: rtl/forwarding_controller.sv
// Operand-forwarding and load-use stall controller between decode and the ALU input mux.
// Optional macro FWD_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module forwarding_controller #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic                  id_src1_used,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  freeze,
  output logic [SEL_W-1:0]      alu_input1_selection,
  output logic [SEL_W-1:0]      alu_input2_selection,
  output logic                  stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [SEL_W-1:0] SEL_RF   = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ALU  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(3);

  typedef enum logic {RUN, STALL} state_e;

  state_e                state_q, state_d;
  logic                  ex_valid, ex_wr, ex_load;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  mem_valid, mem_wr;
  logic [REG_ADDR_W-1:0] mem_dest;

  logic hit_ex1, hit_ex2, hit_mem1, hit_mem2, load_use;

  assign hit_ex1  = id_valid & id_src1_used & ex_valid  & ex_wr  & (ex_dest  == id_src1);
  assign hit_ex2  = id_valid & id_src2_used & ex_valid  & ex_wr  & (ex_dest  == id_src2);
  assign hit_mem1 = id_valid & id_src1_used & mem_valid & mem_wr & (mem_dest == id_src1);
  assign hit_mem2 = id_valid & id_src2_used & mem_valid & mem_wr & (mem_dest == id_src2);
  assign load_use = (hit_ex1 | hit_ex2) & ex_load;

  // Next state, operand selections and stall; the youngest producer wins.
  always_comb begin
    state_d              = state_q;
    alu_input1_selection = SEL_RF;
    alu_input2_selection = SEL_RF;
    stall                = 1'b0;

    if (hit_ex1 & ~ex_load)  alu_input1_selection = SEL_ALU;
    else if (hit_mem1)       alu_input1_selection = SEL_MEM;
    if (hit_ex2 & ~ex_load)  alu_input2_selection = SEL_ALU;
    else if (hit_mem2)       alu_input2_selection = SEL_MEM;

    if (load_use) begin
      alu_input1_selection = SEL_ZERO;
      alu_input2_selection = SEL_ZERO;
      stall                = ~freeze & ~flush;
    end

    case (state_q)
      RUN:     if (load_use & ~freeze) state_d = STALL;
      STALL:   if (~freeze)            state_d = RUN;
      default:                         state_d = RUN;
    endcase
  end

  // EX/MEM shadow slots and FSM; everything holds while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_dest   <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dest  <= '0;
    end else if (!freeze) begin
      state_q   <= state_d;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dest  <= ex_dest;
      ex_valid  <= id_valid & ~stall & ~flush;
      ex_wr     <= id_valid & id_wr_en;
      ex_load   <= id_valid & id_is_load;
      ex_dest   <= id_dest;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
  end
`endif

`ifndef SYNTHESIS
  // A stall cycle leaves a bubble in EX, so a second stall in a row is impossible.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == STALL) && !freeze)
      assert (!load_use && (state_d == RUN))
        else $error("forwarding_controller: STALL held for two unfrozen cycles");
  end
`endif

endmodule

// File: tb/tb_forwarding_controller.sv
// Scoreboard bench for forwarding_controller: directed pipeline scenarios then random traffic.
module tb_forwarding_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_src1_used, id_src2_used, id_wr_en, id_is_load, flush, freeze;
  logic [2:0] id_src1, id_src2, id_dest;
  logic [1:0] alu_input1_selection, alu_input2_selection;
  logic       stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  forwarding_controller #(.REG_ADDR_W(3), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush), .freeze(freeze),
    .alu_input1_selection(alu_input1_selection),
    .alu_input2_selection(alu_input2_selection),
    .stall(stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int dest;
    bit wr;
    bit load;
  } slot_t;

  typedef struct {
    int s1;
    int s2;
    int st;
    int cnt;
  } exp_t;

  slot_t m_ex, m_mem;
  int    m_cnt;
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Where operand `src` comes from, looking at the instructions still in flight.
  function automatic int source_of(input int src, input bit used, output bit hazard);
    hazard = 1'b0;
    if (!id_valid || !used) return 0;
    if (m_ex.valid && m_ex.wr && m_ex.dest == src) begin
      if (m_ex.load) begin
        hazard = 1'b1;
        return 0;
      end
      return 1;
    end
    if (m_mem.valid && m_mem.wr && m_mem.dest == src) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_ex  = '{valid: 1'b0, dest: 0, wr: 1'b0, load: 1'b0};
    m_mem = m_ex;
    m_cnt = 0;
  endfunction

  // Drive one decode cycle, predict the response and advance the model pipeline.
  task automatic issue(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit wr, input bit ld, input bit fl, input bit fz);
    exp_t e;
    bit   h1, h2, st;
    @(negedge clk);
    rst_n        = 1'b1;
    id_valid     = v;
    id_src1      = 3'(s1);
    id_src1_used = u1;
    id_src2      = 3'(s2);
    id_src2_used = u2;
    id_dest      = 3'(d);
    id_wr_en     = wr;
    id_is_load   = ld;
    flush        = fl;
    freeze       = fz;
    #1;
    e.s1 = source_of(s1, u1, h1);
    e.s2 = source_of(s2, u2, h2);
    if (h1 || h2) begin
      e.s1 = 3;
      e.s2 = 3;
    end
    st    = (h1 || h2) && !fz && !fl;
    e.st  = int'(st);
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (!fz) begin
      m_mem = m_ex;
      m_ex  = '{valid: v && !st && !fl, dest: d, wr: v && wr, load: v && ld};
      if (st && m_cnt < 65535) m_cnt++;
    end
  endtask

  // Monitor: compare every predicted response against the DUT outputs.
  always begin
    @(negedge clk);
    #2;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sel1", int'(alu_input1_selection), e.s1);
      check("sel2", int'(alu_input2_selection), e.s2);
      check("stall", int'(stall), e.st);
`ifdef FWD_STALL_CNT_EN
      check("stall_count", int'(stall_count), e.cnt);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int s1, s2, d;
    bit v, u1, u2, wr, ld, fl, fz, hold;
    model_reset();
    rst_n = 1'b0;
    id_valid = 1'b1; id_src1 = 3'd0; id_src1_used = 1'b1; id_src2 = 3'd0; id_src2_used = 1'b1;
    id_dest = 3'd0; id_wr_en = 1'b1; id_is_load = 1'b1; flush = 1'b0; freeze = 1'b0;
    #12;
    check("reset_sel1", int'(alu_input1_selection), 0);
    check("reset_sel2", int'(alu_input2_selection), 0);
    check("reset_stall", int'(stall), 0);
`ifdef FWD_STALL_CNT_EN
    check("reset_stall_count", int'(stall_count), 0);
`endif

    // ALU back-to-back forward
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    issue(1, 3, 1, 1, 1, 7, 1, 0, 0, 0);
    // Distance-two forward through MEM
    issue(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 1, 5, 1, 6, 1, 0, 0, 0);
    // EX has priority over MEM
    issue(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    issue(1, 2, 1, 2, 1, 1, 1, 0, 0, 0);
    // Load-use: one stall, then MEM forward
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    issue(1, 4, 1, 4, 1, 1, 1, 0, 0, 0);
    issue(1, 4, 1, 4, 1, 1, 1, 0, 0, 0);
    // Load-use under freeze, then release
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    repeat (3) issue(1, 4, 1, 0, 0, 1, 1, 0, 0, 1);
    issue(1, 4, 1, 0, 0, 1, 1, 0, 0, 0);
    issue(1, 4, 1, 0, 0, 1, 1, 0, 0, 0);
    // Flush during a hazard
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    issue(1, 0, 0, 4, 1, 1, 1, 0, 1, 0);
    issue(1, 1, 1, 4, 1, 2, 1, 0, 0, 0);
    // Async reset while stalling
    issue(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    issue(1, 6, 1, 0, 0, 1, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", int'(stall), 0);
    check("rst_mid_sel1", int'(alu_input1_selection), 0);
    model_reset();
    @(posedge clk);
    issue(1, 6, 1, 6, 1, 1, 1, 0, 0, 0);

    // Random traffic; a stalled or frozen decode instruction is usually re-presented
    hold = 1'b0;
    s1 = 0; s2 = 0; d = 0; v = 0; u1 = 0; u2 = 0; wr = 0; ld = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold || $urandom_range(0, 3) == 0) begin
        v  = $urandom_range(0, 7) != 0;
        s1 = $urandom_range(0, 3);
        s2 = $urandom_range(0, 3);
        d  = $urandom_range(0, 3);
        u1 = $urandom_range(0, 3) != 0;
        u2 = $urandom_range(0, 3) != 0;
        wr = $urandom_range(0, 4) != 0;
        ld = $urandom_range(0, 2) == 0;
      end
      fl = $urandom_range(0, 9) == 0;
      fz = $urandom_range(0, 6) == 0;
      issue(v, s1, u1, s2, u2, d, wr, ld, fl, fz);
      hold = fz || (exp_q.size() > 0 && exp_q[exp_q.size()-1].st != 0);
    end

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
